// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_sram_responder_pkg : shared widths, FSM encodings, lane helpers   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package data_sram_responder_pkg;

  localparam int DATA_SRAM_WD = 32;
  localparam int DSR_LANES    = 4;
  localparam int DSR_LANE_W   = 8;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int DSR_ST_W = 2;
  localparam logic [DSR_ST_W-1:0] DSR_IDLE = 2'd0;
  localparam logic [DSR_ST_W-1:0] DSR_WAIT = 2'd1;
  localparam logic [DSR_ST_W-1:0] DSR_DONE = 2'd2;

  typedef struct packed {
    logic [DATA_SRAM_WD-1:0] addr;
    logic [DSR_LANES-1:0]    wen;
    logic [DATA_SRAM_WD-1:0] wdata;
  } dsr_req_t;

  function automatic logic [DSR_LANE_W-1:0] dsr_lane(input logic [DATA_SRAM_WD-1:0] word,
                                                      input int lane);
    return word[lane*DSR_LANE_W +: DSR_LANE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_bytewrite_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dsr_bytewrite_ram : single-port synchronous RAM, 4 byte lanes         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dsr_bytewrite_ram
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
)(
  input  logic                    clk,
  input  logic                    en,
  input  logic [DSR_LANES-1:0]    wen,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_SRAM_WD-1:0] wdata,
  output logic [DATA_SRAM_WD-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic rd_en;
  assign rd_en = en && (wen == '0);

  // Read port only updates on a load, so rdata holds across stores and idle cycles.
  for (genvar i = 0; i < DSR_LANES; i++) begin : g_lane
    logic [DSR_LANE_W-1:0] mem [DEPTH];
    logic [DSR_LANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (en && wen[i]) mem[addr] <= dsr_lane(wdata, i);
      if (rd_en)        rd_q      <= mem[addr];
    end

    assign rdata[i*DSR_LANE_W +: DSR_LANE_W] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_sram_responder : data-SRAM responder with optional wait states   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int                      DEPTH_LOG2 = 12,
  parameter int                      LATENCY    = 0,
  parameter logic [DATA_SRAM_WD-1:0] BASE_ADDR  = 32'h0000_0000
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_sram_en,
  input  logic [DSR_LANES-1:0]    data_sram_wen,
  input  logic [DATA_SRAM_WD-1:0] data_sram_addr,
  input  logic [DATA_SRAM_WD-1:0] data_sram_wdata,
  output logic [DATA_SRAM_WD-1:0] data_sram_rdata,
  output logic                    stallreq,
  output logic                    oob_err
);

  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit HAS_WAIT = (LATENCY > 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [DATA_SRAM_WD:0] SPAN =
    {{DATA_SRAM_WD{1'b0}}, 1'b1} << (DEPTH_LOG2 + 2);

  logic [DSR_ST_W-1:0]     state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  dsr_req_t                req_q, req_d;
  logic                    rd_sel_q, rd_sel_d;
  logic                    oob_q, oob_d;

  dsr_req_t                live_req, cur_req;
  logic                    fire, out_of_range, is_load;
  logic [DATA_SRAM_WD-1:0] offset;
  logic [DATA_SRAM_WD-1:0] ram_rdata;

  assign live_req = '{addr: data_sram_addr, wen: data_sram_wen, wdata: data_sram_wdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DSR_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rd_sel_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rd_sel_q <= rd_sel_d;
      oob_q    <= oob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      DSR_IDLE: begin
        if (data_sram_en) begin
          req_d = live_req;
          if (HAS_WAIT) begin
            state_d = DSR_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DSR_WAIT: begin
        if (cnt_q == '0) state_d = DSR_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DSR_DONE: state_d = DSR_IDLE;
      default:  state_d = DSR_IDLE;
    endcase
  end

  // Zero-latency accesses execute straight from the pins; delayed ones from the latch.
  always_comb begin
    cur_req = (state_q == DSR_DONE) ? req_q : live_req;
    fire    = 1'b0;
    if (rst) begin
      if (state_q == DSR_DONE)
        fire = 1'b1;
      else if ((state_q == DSR_IDLE) && data_sram_en && !HAS_WAIT)
        fire = 1'b1;
    end
    offset       = cur_req.addr - BASE_ADDR;
    out_of_range = (cur_req.addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
    is_load      = (cur_req.wen == '0);

    stallreq = NO_STOP;
    if (rst && ((state_q == DSR_WAIT) ||
                ((state_q == DSR_IDLE) && data_sram_en && HAS_WAIT)))
      stallreq = STOP;

    oob_d    = fire && out_of_range;
    rd_sel_d = (fire && is_load) ? !out_of_range : rd_sel_q;
  end

  dsr_bytewrite_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (fire && !out_of_range),
    .wen   (cur_req.wen),
    .addr  (offset[DEPTH_LOG2+1:2]),
    .wdata (cur_req.wdata),
    .rdata (ram_rdata)
  );

  assign data_sram_rdata = rd_sel_q ? ram_rdata : '0;
  assign oob_err         = oob_q;

endmodule
`default_nettype wire
